// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding and round-robin helper for apb_req_arbiter
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_e;

   // Largest requester count the helper can search.
   localparam int unsigned RR_MAX = 8;

   // Returns {valid, index}. The search starts one past the last grant and
   // wraps modulo n, so the previous winner is considered last.
   function automatic logic [3:0] rr_pick(input logic [7:0]  req,
                                          input logic [2:0]  last,
                                          input int unsigned n);
      logic [3:0]  res;
      int unsigned idx;
      res = '0;
      for (int unsigned k = 1; k <= RR_MAX; k++) begin
         idx = (32'(last) + k) % n;
         if (k <= n && !res[3] && req[idx[2:0]]) begin
            res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester-side and peripheral-side APB signals of the arbiter
interface apb_req_arbiter_if #(
   parameter int NB_REQ         = 2,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);

   // Requester side: the arbiter acts as an APB slave to each requester.
   logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0] req_paddr_i;
   logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0] req_pwdata_i;
   logic [NB_REQ-1:0]                     req_pwrite_i;
   logic [NB_REQ-1:0]                     req_psel_i;
   logic [NB_REQ-1:0]                     req_penable_i;
   logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0] req_prdata_o;
   logic [NB_REQ-1:0]                     req_pready_o;
   logic [NB_REQ-1:0]                     req_pslverr_o;

   // Peripheral side: the arbiter acts as the single APB master.
   logic [APB_ADDR_WIDTH-1:0]             m_paddr_o;
   logic [APB_DATA_WIDTH-1:0]             m_pwdata_o;
   logic                                  m_pwrite_o;
   logic                                  m_psel_o;
   logic                                  m_penable_o;
   logic [APB_DATA_WIDTH-1:0]             m_prdata_i;
   logic                                  m_pready_i;
   logic                                  m_pslverr_i;

   // The arbiter's view: it drives the peripheral bus and the requester responses.
   modport master (
      input  req_paddr_i, req_pwdata_i, req_pwrite_i, req_psel_i, req_penable_i,
      output req_prdata_o, req_pready_o, req_pslverr_o,
      output m_paddr_o, m_pwdata_o, m_pwrite_o, m_psel_o, m_penable_o,
      input  m_prdata_i, m_pready_i, m_pslverr_i
   );

   // The environment's view: requesters plus the peripheral bus slave.
   modport slave (
      output req_paddr_i, req_pwdata_i, req_pwrite_i, req_psel_i, req_penable_i,
      input  req_prdata_o, req_pready_o, req_pslverr_o,
      input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_psel_o, m_penable_o,
      output m_prdata_i, m_pready_i, m_pslverr_i
   );

endinterface

// File: rtl/apb_rr_picker.sv
// rtl/apb_rr_picker.sv - combinational round-robin winner selection
module apb_rr_picker
   import apb_arb_pkg::*;
#(
   parameter int NB_REQ = 2,
   parameter int IDX_W  = 1
) (
   input  logic [NB_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]  last_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   logic [3:0] pick;

   // Search the request vector starting after the previous winner.
   always_comb begin
      pick = rr_pick(8'(req_i), 3'(last_i), NB_REQ);
   end

   assign valid_o = pick[3];
   assign idx_o   = IDX_W'(pick[2:0]);

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin APB requester arbiter; APB_ARB_TIMEOUT_EN enables the ACCESS timeout
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NB_REQ         = 2,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   apb_req_arbiter_if.master bus
);

   localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

   arb_state_e                state_q, state_d;
   logic [IDX_W-1:0]          grant_q;
   logic [IDX_W-1:0]          last_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;
   logic                      write_q;

   logic [IDX_W-1:0]          win_idx;
   logic                      win_valid;
   logic                      done;
   logic                      expire;
   logic                      live;

   apb_rr_picker #(
      .NB_REQ (NB_REQ),
      .IDX_W  (IDX_W)
   ) u_picker (
      .req_i   (bus.req_psel_i),
      .last_i  (last_q),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] cnt_q;

   // Count ACCESS cycles spent waiting on the peripheral; restart each SETUP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS && !bus.m_pready_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire = (state_q == ACCESS) && !bus.m_pready_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expire = 1'b0;

   // TIMEOUT_CYCLES only matters with the timeout built in; keep it referenced.
   if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
   end
`endif

   // State, grant bookkeeping and the latched transfer of the winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NB_REQ - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && win_valid) begin
            grant_q <= win_idx;
            last_q  <= win_idx;
            addr_q  <= bus.req_paddr_i[win_idx];
            wdata_q <= bus.req_pwdata_i[win_idx];
            write_q <= bus.req_pwrite_i[win_idx];
         end
      end
   end

   // Next state and peripheral-side phase controls.
   always_comb begin
      state_d         = state_q;
      bus.m_psel_o    = 1'b0;
      bus.m_penable_o = 1'b0;
      done            = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) state_d = SETUP;
         end
         SETUP: begin
            bus.m_psel_o = 1'b1;
            state_d      = ACCESS;
         end
         ACCESS: begin
            bus.m_psel_o    = 1'b1;
            bus.m_penable_o = 1'b1;
            if (bus.m_pready_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (expire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.m_paddr_o  = addr_q;
   assign bus.m_pwdata_o = wdata_q;
   assign bus.m_pwrite_o = write_q;

   // A requester that abandoned its transfer gets no response.
   assign live = bus.req_psel_i[grant_q] & bus.req_penable_i[grant_q];

   // Route the completion (or timeout error) back to the granted requester only.
   always_comb begin
      bus.req_pready_o  = '0;
      bus.req_pslverr_o = '0;
      bus.req_prdata_o  = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (grant_q == IDX_W'(i) && live && (done || expire)) begin
            bus.req_pready_o[i]  = 1'b1;
            bus.req_pslverr_o[i] = done ? bus.m_pslverr_i : 1'b1;
            bus.req_prdata_o[i]  = done ? bus.m_prdata_i : '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   apb_req_arbiter_if #(.NB_REQ(3), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

   apb_req_arbiter #(
      .NB_REQ         (3),
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_paddr_i   = '0;
      bus.req_pwdata_i  = '0;
      bus.req_pwrite_i  = '0;
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;
      bus.m_prdata_i    = '0;
      bus.m_pready_i    = 1'b0;
      bus.m_pslverr_i   = 1'b0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear_inputs();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_psel", bus.m_psel_o, 1'b0);
      check("rst_penable", bus.m_penable_o, 1'b0);
      check("rst_paddr", bus.m_paddr_o, 32'h0);
      check("rst_pwdata", bus.m_pwdata_o, 32'h0);
      check("rst_pready", bus.req_pready_o, 3'b000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single zero-wait read by requester 0
      bus.m_pready_i     = 1'b1;
      bus.m_prdata_i     = 32'hDEAD_BEEF;
      bus.req_psel_i[0]  = 1'b1;
      bus.req_paddr_i[0] = 32'h1A10_0000;
      @(negedge clk);
      check("rd_c0_psel", bus.m_psel_o, 1'b0);
      step();
      bus.req_penable_i[0] = 1'b1;
      @(negedge clk);
      check("rd_c1_psel", bus.m_psel_o, 1'b1);
      check("rd_c1_penable", bus.m_penable_o, 1'b0);
      check("rd_c1_paddr", bus.m_paddr_o, 32'h1A10_0000);
      check("rd_c1_pwrite", bus.m_pwrite_o, 1'b0);
      check("rd_c1_pready", bus.req_pready_o, 3'b000);
      step();
      @(negedge clk);
      check("rd_c2_penable", bus.m_penable_o, 1'b1);
      check("rd_c2_pready", bus.req_pready_o, 3'b001);
      check("rd_c2_prdata0", bus.req_prdata_o[0], 32'hDEAD_BEEF);
      check("rd_c2_prdata1", bus.req_prdata_o[1], 32'h0);
      step();
      bus.req_psel_i[0]    = 1'b0;
      bus.req_penable_i[0] = 1'b0;
      @(negedge clk);
      check("rd_c3_psel", bus.m_psel_o, 1'b0);
      check("rd_c3_pready", bus.req_pready_o, 3'b000);

      // contention between requesters 0 and 1 from reset
      reset_dut();
      bus.m_pready_i     = 1'b1;
      bus.m_prdata_i     = 32'h0000_0011;
      bus.req_psel_i     = 3'b011;
      bus.req_paddr_i[0] = 32'h0000_1000;
      bus.req_paddr_i[1] = 32'h0000_2000;
      step();
      bus.req_penable_i = 3'b011;
      @(negedge clk);
      check("ct_setup0_paddr", bus.m_paddr_o, 32'h0000_1000);
      check("ct_setup0_pready", bus.req_pready_o, 3'b000);
      step();
      @(negedge clk);
      check("ct_access0_pready", bus.req_pready_o, 3'b001);
      step();
      bus.req_psel_i[0]    = 1'b0;
      bus.req_penable_i[0] = 1'b0;
      @(negedge clk);
      check("ct_idle_psel", bus.m_psel_o, 1'b0);
      check("ct_idle_pready", bus.req_pready_o, 3'b000);
      step();
      @(negedge clk);
      check("ct_setup1_psel", bus.m_psel_o, 1'b1);
      check("ct_setup1_paddr", bus.m_paddr_o, 32'h0000_2000);
      check("ct_setup1_pready", bus.req_pready_o, 3'b000);
      step();
      @(negedge clk);
      check("ct_access1_pready", bus.req_pready_o, 3'b010);
      check("ct_access1_prdata", bus.req_prdata_o[1], 32'h0000_0011);
      step();
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;

      // fairness: three requesters always requesting
      reset_dut();
      bus.m_pready_i     = 1'b1;
      bus.req_psel_i     = 3'b111;
      bus.req_paddr_i[0] = 32'h0000_0100;
      bus.req_paddr_i[1] = 32'h0000_0200;
      bus.req_paddr_i[2] = 32'h0000_0300;
      for (int t = 0; t < 9; t++) begin
         int g;
         g = t % 3;
         step();
         bus.req_penable_i = 3'b111;
         @(negedge clk);
         check($sformatf("rr_t%0d_paddr", t), bus.m_paddr_o, 64'(32'h100 * (g + 1)));
         step();
         @(negedge clk);
         check($sformatf("rr_t%0d_pready", t), bus.req_pready_o, 64'(3'b001 << g));
         step();
         bus.req_penable_i[g] = 1'b0;
         @(negedge clk);
         check($sformatf("rr_t%0d_idle", t), bus.m_psel_o, 1'b0);
      end
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;

      // write with five wait states, then slave error
      reset_dut();
      bus.req_psel_i[0]   = 1'b1;
      bus.req_pwrite_i[0] = 1'b1;
      bus.req_paddr_i[0]  = 32'h1A10_0040;
      bus.req_pwdata_i[0] = 32'hCAFE_F00D;
      step();
      bus.req_penable_i[0] = 1'b1;
      bus.req_paddr_i[0]   = 32'hFFFF_FFFF;
      bus.req_pwdata_i[0]  = 32'h0;
      @(negedge clk);
      check("ws_setup_paddr", bus.m_paddr_o, 32'h1A10_0040);
      check("ws_setup_pwdata", bus.m_pwdata_o, 32'hCAFE_F00D);
      check("ws_setup_pwrite", bus.m_pwrite_o, 1'b1);
      for (int w = 0; w < 5; w++) begin
         step();
         @(negedge clk);
         check($sformatf("ws_w%0d_paddr", w), bus.m_paddr_o, 32'h1A10_0040);
         check($sformatf("ws_w%0d_pwdata", w), bus.m_pwdata_o, 32'hCAFE_F00D);
         check($sformatf("ws_w%0d_penable", w), bus.m_penable_o, 1'b1);
         check($sformatf("ws_w%0d_pready", w), bus.req_pready_o, 3'b000);
      end
      step();
      bus.m_pready_i  = 1'b1;
      bus.m_pslverr_i = 1'b1;
      @(negedge clk);
      check("ws_done_paddr", bus.m_paddr_o, 32'h1A10_0040);
      check("ws_done_pready", bus.req_pready_o, 3'b001);
      check("ws_done_pslverr", bus.req_pslverr_o, 3'b001);
      step();
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;
      bus.m_pslverr_i   = 1'b0;
      @(negedge clk);
      check("ws_after_pready", bus.req_pready_o, 3'b000);
      check("ws_after_pslverr", bus.req_pslverr_o, 3'b000);
      check("ws_after_psel", bus.m_psel_o, 1'b0);

      // slave that never answers within 16 ACCESS cycles
      reset_dut();
      bus.m_prdata_i     = 32'h5555_AAAA;
      bus.req_psel_i[0]  = 1'b1;
      bus.req_paddr_i[0] = 32'h1A10_0080;
      step();
      bus.req_penable_i[0] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         @(negedge clk);
`ifdef APB_ARB_TIMEOUT_EN
         if (k < 16) begin
            check($sformatf("to_k%0d_pready", k), bus.req_pready_o, 3'b000);
         end else begin
            check("to_fire_pready", bus.req_pready_o, 3'b001);
            check("to_fire_pslverr", bus.req_pslverr_o, 3'b001);
            check("to_fire_prdata", bus.req_prdata_o[0], 32'h0);
         end
`else
         check($sformatf("nt_k%0d_pready", k), bus.req_pready_o, 3'b000);
         check($sformatf("nt_k%0d_penable", k), bus.m_penable_o, 1'b1);
`endif
      end
`ifdef APB_ARB_TIMEOUT_EN
      step();
      bus.req_psel_i     = 3'b010;
      bus.req_penable_i  = 3'b000;
      bus.req_paddr_i[1] = 32'h1A10_00C0;
      bus.m_pready_i     = 1'b1;
      @(negedge clk);
      check("to_idle_psel", bus.m_psel_o, 1'b0);
      step();
      bus.req_penable_i[1] = 1'b1;
      @(negedge clk);
      check("to_next_psel", bus.m_psel_o, 1'b1);
      check("to_next_paddr", bus.m_paddr_o, 32'h1A10_00C0);
      step();
      @(negedge clk);
      check("to_next_pready", bus.req_pready_o, 3'b010);
`else
      step();
      bus.m_pready_i = 1'b1;
      @(negedge clk);
      check("nt_done_pready", bus.req_pready_o, 3'b001);
      check("nt_done_pslverr", bus.req_pslverr_o, 3'b000);
      check("nt_done_prdata", bus.req_prdata_o[0], 32'h5555_AAAA);
`endif
      step();
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;

      // reset asserted while waiting in ACCESS
      reset_dut();
      bus.req_psel_i[0]  = 1'b1;
      bus.req_paddr_i[0] = 32'h0000_3000;
      step();
      bus.req_penable_i[0] = 1'b1;
      step();
      step();
      @(negedge clk);
      check("rm_wait_penable", bus.m_penable_o, 1'b1);
      #1;
      rst_n              = 1'b0;
      bus.m_pready_i     = 1'b1;
      bus.req_psel_i[1]  = 1'b1;
      bus.req_paddr_i[1] = 32'h0000_4000;
      #1;
      check("rm_async_psel", bus.m_psel_o, 1'b0);
      check("rm_async_penable", bus.m_penable_o, 1'b0);
      check("rm_async_pready", bus.req_pready_o, 3'b000);
      @(posedge clk);
      #1;
      rst_n             = 1'b1;
      bus.req_penable_i = 3'b000;
      step();
      bus.req_penable_i = 3'b011;
      @(negedge clk);
      check("rm_after_paddr", bus.m_paddr_o, 32'h0000_3000);
      step();
      @(negedge clk);
      check("rm_after_pready", bus.req_pready_o, 3'b001);
      step();
      bus.req_psel_i    = '0;
      bus.req_penable_i = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
